// File: rtl/decimal_counter.sv
// Purpose : run/stop up/down decimal counter (0..MAX_COUNT) for a 4-digit 7-segment display.
// Latency : display_number/wrap/running change on the edge that applies a tick, clear or start press.
// Flow    : no backpressure; raw button/switch inputs are synchronized and debounced internally.
//
// Ports:
//   clk            - single clock, all state changes on its rising edge
//   rst            - asynchronous active-high reset
//   btn_start      - raw push button, each accepted press toggles STOP/RUN
//   btn_clear      - raw push button, each accepted press zeroes count and prescaler
//   dir            - raw slide switch, 1 = count up, 0 = count down (synchronized only)
//   display_number - registered binary count 0..MAX_COUNT
//   running        - registered, high while in RUN
//   wrap           - registered one-cycle pulse when the count wraps around
module decimal_counter #(
  parameter int TICK_DIV        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_COUNT       = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        dir,
  output logic [15:0] display_number,
  output logic        running,
  output logic        wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]   COUNT_MAX  = 16'(MAX_COUNT);

  // Button index map for the packed per-button vectors below.
  localparam int B_START = 0;
  localparam int B_CLEAR = 1;
  localparam int NB      = 2;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------
  // Input synchronizers (two flops per raw input)
  // --------------------------------------------------------------------
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_meta_q;
  logic [NB-1:0] btn_sync_q;
  logic          dir_meta_q;
  logic          dir_sync_q;

  assign btn_raw = {btn_clear, btn_start};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      dir_meta_q <= 1'b0;
      dir_sync_q <= 1'b0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      dir_meta_q <= dir;
      dir_sync_q <= dir_meta_q;
    end
  end

  // --------------------------------------------------------------------
  // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement with the currently accepted level. Any cycle
  // of agreement restarts the count, so short glitches never get through.
  // --------------------------------------------------------------------
  logic [NB-1:0][DW-1:0] db_cnt_q;
  logic [NB-1:0][DW-1:0] db_cnt_d;
  logic [NB-1:0]         acc_q;
  logic [NB-1:0]         acc_d;
  logic [NB-1:0]         press;

  always_comb begin
    db_cnt_d = db_cnt_q;
    acc_d    = acc_q;
    press    = '0;
    for (int b = 0; b < NB; b++) begin
      if (btn_sync_q[b] == acc_q[b]) begin
        db_cnt_d[b] = '0;
      end else if (db_cnt_q[b] == DB_LAST) begin
        acc_d[b]    = btn_sync_q[b];
        db_cnt_d[b] = '0;
        // The acceptance edge is the 0->1 transition itself, so the press
        // pulse is derived here rather than from a delayed copy of acc_q.
        press[b]    = btn_sync_q[b];
      end else begin
        db_cnt_d[b] = db_cnt_q[b] + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= '0;
      acc_q    <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      acc_q    <= acc_d;
    end
  end

  logic start_press;
  logic clear_press;

  assign start_press = press[B_START];
  assign clear_press = press[B_CLEAR];

  // --------------------------------------------------------------------
  // Run/stop FSM
  // --------------------------------------------------------------------
  state_t state_q;
  state_t state_d;

  always_comb begin
    state_d = state_q;
    if (start_press) begin
      case (state_q)
        ST_STOP: state_d = ST_RUN;
        ST_RUN:  state_d = ST_STOP;
        default: state_d = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------
  // Prescaler: counts only while RUN is held across the edge. Forcing it
  // to zero on the entry edge places the first tick exactly TICK_DIV
  // cycles after the transition.
  // --------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick;

  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if ((state_q != ST_RUN) || (state_d != ST_RUN) || clear_press || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // --------------------------------------------------------------------
  // Count and wrap pulse. Clear wins over a coincident tick and also
  // suppresses the wrap pulse that tick would have produced.
  // --------------------------------------------------------------------
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        wrap_q;
  logic        wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear_press) begin
      count_d = '0;
    end else if (tick) begin
      if (dir_sync_q) begin
        if (count_q >= COUNT_MAX) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 16'd1;
        end
      end else begin
        if (count_q == 16'd0) begin
          count_d = COUNT_MAX;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign display_number = count_q;
  assign wrap           = wrap_q;
  // state_q is a single flop, so this is a registered output.
  assign running        = (state_q == ST_RUN);

endmodule

// File: tb/tb_decimal_counter.sv
// Purpose : directed bench for decimal_counter with a queue scoreboard on display/wrap events.
// Latency : expected events are queued ahead of the stimulus and popped when the DUT shows them.
// Flow    : monitor samples on the falling edge; stimulus drives inputs on the falling edge.
module tb_decimal_counter;

  logic        clk;
  logic        rst;
  logic        btn_start;
  logic        btn_clear;
  logic        dir;
  logic [15:0] display_number;
  logic        running;
  logic        wrap;

  decimal_counter #(
    .TICK_DIV        (4),
    .DEBOUNCE_CYCLES (3),
    .MAX_COUNT       (9999)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start      (btn_start),
    .btn_clear      (btn_clear),
    .dir            (dir),
    .display_number (display_number),
    .running        (running),
    .wrap           (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int disp;
    int wrp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   start_cnt = 0;
  int   clear_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int w);
    exp_t e;
    e.disp = d;
    e.wrp  = w;
    sb.push_back(e);
  endtask

  // One falling edge; also releases buttons whose hold time has run out.
  task automatic step();
    @(negedge clk);
    if (start_cnt > 0) begin
      start_cnt--;
      if (start_cnt == 0) btn_start = 1'b0;
    end
    if (clear_cnt > 0) begin
      clear_cnt--;
      if (clear_cnt == 0) btn_clear = 1'b0;
    end
  endtask

  task automatic wait_disp(input string name, input int v, input int maxc, output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < maxc) begin
      step();
      cyc++;
      if (int'(display_number) == v) ok = 1'b1;
    end
    check({name, "_reached"}, int'(ok), 1);
  endtask

  task automatic wait_run(input string name, input bit lvl, input int maxc, output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < maxc) begin
      step();
      cyc++;
      if (running == lvl) ok = 1'b1;
    end
    check({name, "_running"}, int'(ok), 1);
  endtask

  // Monitor: any change of display_number or any high wrap is one output event.
  initial begin
    logic [15:0] prev_disp;
    exp_t        e;
    prev_disp = '0;
    forever begin
      @(negedge clk);
      if (display_number != prev_disp || wrap) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got disp %0d wrap %0d, expected no event",
                   display_number, wrap);
        end else begin
          e = sb.pop_front();
          check("sb_disp", int'(display_number), e.disp);
          check("sb_wrap", int'(wrap), e.wrp);
        end
        prev_disp = display_number;
      end
    end
  end

  initial begin
    int cyc;
    rst       = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    dir       = 1'b0;
    #1 rst = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_disp", int'(display_number), 0);
    check("rst_running", int'(running), 0);
    check("rst_wrap", int'(wrap), 0);
    rst = 1'b0;

    // Two-cycle glitch on start must be rejected
    repeat (3) step();
    btn_start = 1'b1;
    repeat (2) step();
    btn_start = 1'b0;
    repeat (20) step();
    check("glitch_running", int'(running), 0);
    check("glitch_disp", int'(display_number), 0);

    // Start, count up 1..7 at one step per 4 cycles, stop at 7
    for (int v = 1; v <= 7; v++) push(v, 0);
    dir       = 1'b1;
    btn_start = 1'b1;
    start_cnt = 10;
    wait_run("start", 1'b1, 6, cyc);
    for (int v = 1; v <= 6; v++) begin
      wait_disp("step", v, 10, cyc);
      check("step_period", cyc, 4);
    end
    // Press lands 4 edges later, right after the tick that shows 7.
    btn_start = 1'b1;
    start_cnt = 6;
    wait_disp("step7", 7, 10, cyc);
    check("step_period", cyc, 4);
    wait_run("stop", 1'b0, 6, cyc);
    repeat (50) step();
    check("hold_disp", int'(display_number), 7);
    check("hold_running", int'(running), 0);

    // Clear while stopped
    push(0, 0);
    btn_clear = 1'b1;
    clear_cnt = 5;
    wait_disp("clr_stop", 0, 10, cyc);
    check("clr_stop_running", int'(running), 0);

    // Up to 9999, wrap to 0, down-wrap to 9999, clear on a tick, up to 5, reset
    for (int v = 1; v <= 9999; v++) push(v, 0);
    push(0, 1);
    push(9999, 1);
    push(9998, 0);
    push(0, 0);
    for (int v = 1; v <= 5; v++) push(v, 0);
    push(0, 0);
    repeat (10) step();
    btn_start = 1'b1;
    start_cnt = 6;
    wait_run("run2", 1'b1, 8, cyc);
    wait_disp("up_to_max", 9999, 40100, cyc);
    wait_disp("up_wrap", 0, 6, cyc);
    check("up_wrap_pulse", int'(wrap), 1);
    dir = 1'b0;
    step();
    check("up_wrap_len", int'(wrap), 0);
    wait_disp("down_wrap", 9999, 6, cyc);
    check("down_wrap_pulse", int'(wrap), 1);
    step();
    check("down_wrap_len", int'(wrap), 0);
    // Clear accepted 4 edges after this drive, i.e. on the second tick after the wrap.
    step();
    step();
    btn_clear = 1'b1;
    clear_cnt = 6;
    wait_disp("pre_clr", 9998, 6, cyc);
    wait_disp("clr_tick", 0, 6, cyc);
    check("clr_tick_cycles", cyc, 4);
    check("clr_tick_wrap", int'(wrap), 0);
    check("clr_tick_running", int'(running), 1);
    dir = 1'b1;
    wait_disp("pre_rst", 5, 40, cyc);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    check("arst_disp", int'(display_number), 0);
    check("arst_running", int'(running), 0);
    check("arst_wrap", int'(wrap), 0);
    step();
    rst = 1'b0;
    repeat (20) step();
    check("post_rst_disp", int'(display_number), 0);
    check("post_rst_running", int'(running), 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
